// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-port round-robin arbiter in front of a single-port
//               synchronous memory. One access per three cycles:
//               gnt in cycle N (ACCESS), memory read in cycle N+1 (RESP),
//               done/rdata in cycle N+2 (back in IDLE).
//               Optional grant locking is compiled in with MEM_ARB_LOCK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int LOCK_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
`ifdef MEM_ARB_LOCK_EN
  input  logic              lock0,
  input  logic              lock1,
`endif
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic              any_req;
  logic              winner;     // 0 = port 0, 1 = port 1
  logic              last;       // port served most recently
  logic              owner;      // port owning the access in flight
  logic              owner_we;   // access in flight is a write

  logic              gnt0_nxt;
  logic              gnt1_nxt;
  logic              done0_nxt;
  logic              done1_nxt;
  logic              mem_we_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [DATA_W-1:0] mem_wdata_nxt;
  logic [DATA_W-1:0] rdata_nxt;
  logic              owner_nxt;
  logic              owner_we_nxt;
  logic              last_nxt;

  assign any_req = req0 | req1;
  assign busy    = (state != IDLE);

`ifdef MEM_ARB_LOCK_EN
  localparam int               CNT_W   = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] lock_cnt;
  logic             last_lock;
  logic             last_req;
  logic             lock_hold;

  // The last owner keeps the grant while it locks and has budget left
  assign last_lock = last ? lock1 : lock0;
  assign last_req  = last ? req1  : req0;
  assign lock_hold = last_lock && last_req && (lock_cnt < CNT_MAX);
`endif

  // Winner selection: round-robin on contention, lone requester always wins
  always_comb begin
    winner = 1'b0;
    if (req0 && req1) begin
      winner = ~last;
    end else begin
      winner = req1;
    end
`ifdef MEM_ARB_LOCK_EN
    if (lock_hold) begin
      winner = last;
    end
`endif
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: next values of every registered output and bookkeeping
  always_comb begin
    gnt0_nxt      = 1'b0;
    gnt1_nxt      = 1'b0;
    done0_nxt     = 1'b0;
    done1_nxt     = 1'b0;
    mem_we_nxt    = 1'b0;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    rdata_nxt     = rdata;
    owner_nxt     = owner;
    owner_we_nxt  = owner_we;
    last_nxt      = last;
    case (state)
      IDLE: begin
        if (any_req) begin
          gnt0_nxt      = ~winner;
          gnt1_nxt      = winner;
          mem_we_nxt    = winner ? we1    : we0;
          mem_addr_nxt  = winner ? addr1  : addr0;
          mem_wdata_nxt = winner ? wdata1 : wdata0;
          owner_nxt     = winner;
          owner_we_nxt  = winner ? we1    : we0;
        end
      end
      ACCESS: begin
        // mem_addr holds; mem_we falls back to 0 by default
      end
      RESP: begin
        done0_nxt = ~owner;
        done1_nxt = owner;
        if (!owner_we) begin
          rdata_nxt = mem_rdata;
        end
        last_nxt = owner;
      end
      default: begin
      end
    endcase
  end

  // Registered outputs; reset leaves port 1 as last served so port 0 wins first
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
      owner     <= 1'b0;
      owner_we  <= 1'b0;
      last      <= 1'b1;
    end else begin
      gnt0      <= gnt0_nxt;
      gnt1      <= gnt1_nxt;
      done0     <= done0_nxt;
      done1     <= done1_nxt;
      mem_we    <= mem_we_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      rdata     <= rdata_nxt;
      owner     <= owner_nxt;
      owner_we  <= owner_we_nxt;
      last      <= last_nxt;
    end
  end

`ifdef MEM_ARB_LOCK_EN
  // Consecutive-access counter: restarts on owner change or unlocked grant,
  // clears when the last owner drops lock while idle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lock_cnt <= '0;
    end else if (state == IDLE) begin
      if (any_req) begin
        if ((winner == last) && last_lock) begin
          if (lock_cnt != CNT_MAX) begin
            lock_cnt <= lock_cnt + CNT_ONE;
          end
        end else begin
          lock_cnt <= CNT_ONE;
        end
      end else if (!last_lock) begin
        lock_cnt <= '0;
      end
    end
  end
`endif

endmodule
`default_nettype wire
